fetch_queue: RTL and testbench

Small instruction prefetch FIFO between the PC/instruction-memory fetch stage and the decode stage of the pipelined MIPS core. Each cycle it captures the {PC, instruction} pair produced by fetch, buffers up to DEPTH pairs, and presents the oldest pair to decode. It generates the fetch stall (Stall_F) when full and supports redirect flushes from decode.

---
 rtl/fetch_queue.sv | 109 ++++++++++
 tb/tb_fetch_queue.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch FIFO between the fetch and decode stages.
// Holds up to DEPTH {PC, instruction} pairs in a circular buffer and presents
// the oldest pair to decode with zero read latency. Raises Stall_F when full.
// Optional build macro DELAY_SLOT_EN: when defined, a Flush keeps the branch
// delay slot (the head entry, or the incoming pair when the queue is empty)
// instead of discarding every entry.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [31:0]   PC_F,
    input  logic [31:0]   Instr_F,
    input  logic          Fetch_Valid,
    output logic          Stall_F,
    input  logic          Flush,
    input  logic          Stall_D,
    output logic [31:0]   PC_D,
    output logic [31:0]   Instr_D,
    output logic          Valid_D,
    output logic [AW:0]   Count
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [63:0]   mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          push;
    logic          pop;
    logic [63:0]   head;

    // Show-ahead outputs: head entry is visible whenever the queue is non-empty.
    always_comb begin
        head    = mem_q[rd_ptr_q];
        Valid_D = (count_q != '0);
        Stall_F = (count_q == FULL_COUNT);
        Count   = count_q;
        PC_D    = Valid_D ? head[63:32] : 32'h0;
        Instr_D = Valid_D ? head[31:0]  : 32'h0;
    end

    // Next-state for pointers, occupancy and the storage write port.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        wr_en    = 1'b0;
        wr_addr  = wr_ptr_q;
        push     = Fetch_Valid & ~Stall_F & ~Flush;
        pop      = Valid_D & ~Stall_D & ~Flush;

        if (Flush) begin
`ifdef DELAY_SLOT_EN
            // Keep the delay slot: the head if present, else the incoming pair.
            if (count_q != '0) begin
                wr_ptr_d = rd_ptr_q + AW'(1);
                count_d  = (AW+1)'(1);
            end else if (Fetch_Valid) begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + AW'(1);
                count_d  = (AW+1)'(1);
            end
`else
            // Discard everything, including any pair arriving this cycle.
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
`endif
        end else begin
            if (push) begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + (AW+1)'(1);
            end else if (pop && !push) begin
                count_d = count_q - (AW+1)'(1);
            end
        end
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents are never reset, writes are blocked during reset.
    always_ff @(posedge CLK) begin
        if (RESET && wr_en) begin
            mem_q[wr_addr] <= {PC_F, Instr_F};
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=4). The flush scenario
// follows the DELAY_SLOT_EN build macro so it matches the compiled RTL.
module tb_fetch_queue;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] PC_F;
    logic [31:0] Instr_F;
    logic        Fetch_Valid;
    logic        Stall_F;
    logic        Flush;
    logic        Stall_D;
    logic [31:0] PC_D;
    logic [31:0] Instr_D;
    logic        Valid_D;
    logic [2:0]  Count;

    int checks   = 0;
    int failures = 0;

    fetch_queue #(.DEPTH(4), .AW(2)) dut (
        .CLK(CLK), .RESET(RESET), .PC_F(PC_F), .Instr_F(Instr_F),
        .Fetch_Valid(Fetch_Valid), .Stall_F(Stall_F), .Flush(Flush),
        .Stall_D(Stall_D), .PC_D(PC_D), .Instr_D(Instr_D),
        .Valid_D(Valid_D), .Count(Count)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic fv, input logic [31:0] pc, input logic sd, input logic fl);
        Fetch_Valid = fv;
        PC_F        = pc;
        Instr_F     = pc ^ 32'hA5A5_0000;
        Stall_D     = sd;
        Flush       = fl;
    endtask

    task automatic test_reset();
        RESET = 1'b0;
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        step();
        step();
        checks++; if (Count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", Count); end
        checks++; if (Valid_D !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", Valid_D); end
        checks++; if (Stall_F !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", Stall_F); end
        checks++; if (PC_D !== 32'h0 || Instr_D !== 32'h0) begin failures++; $display("FAIL reset_data got=%h/%h exp=0/0", PC_D, Instr_D); end
        RESET = 1'b1;
    endtask

    task automatic test_fill_full();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h3000 + 32'(4*i), 1'b1, 1'b0);
            step();
            checks++; if (Count !== 3'(i+1)) begin failures++; $display("FAIL fill_count%0d got=%0d exp=%0d", i, Count, i+1); end
            checks++; if (PC_D !== 32'h3000 || Instr_D !== (32'h3000 ^ 32'hA5A5_0000) || Valid_D !== 1'b1)
                begin failures++; $display("FAIL fill_head%0d got=%h/%h v=%b exp=00003000", i, PC_D, Instr_D, Valid_D); end
        end
        checks++; if (Stall_F !== 1'b1) begin failures++; $display("FAIL full_stall got=%b exp=1", Stall_F); end
        // Full: push blocked, pop happens.
        drive(1'b1, 32'h3010, 1'b0, 1'b0);
        step();
        checks++; if (Count !== 3'd3 || PC_D !== 32'h3004) begin failures++; $display("FAIL full_pop got=%0d/%h exp=3/00003004", Count, PC_D); end
        checks++; if (Stall_F !== 1'b0) begin failures++; $display("FAIL full_release got=%b exp=0", Stall_F); end
        // Push and pop together: count unchanged.
        step();
        checks++; if (Count !== 3'd3 || PC_D !== 32'h3008) begin failures++; $display("FAIL pushpop got=%0d/%h exp=3/00003008", Count, PC_D); end
        // Drain: 0x3008, 0x300C, 0x3010 in order.
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        step();
        checks++; if (Count !== 3'd2 || PC_D !== 32'h300C) begin failures++; $display("FAIL drain1 got=%0d/%h exp=2/0000300c", Count, PC_D); end
        step();
        checks++; if (Count !== 3'd1 || PC_D !== 32'h3010) begin failures++; $display("FAIL drain2 got=%0d/%h exp=1/00003010", Count, PC_D); end
        step();
        checks++; if (Count !== 3'd0 || Valid_D !== 1'b0 || PC_D !== 32'h0) begin failures++; $display("FAIL drain3 got=%0d/%b/%h exp=0/0/0", Count, Valid_D, PC_D); end
    endtask

    task automatic test_wrap();
        int sent = 0;
        int got  = 0;
        int cyc  = 0;
        int errs = 0;
        int maxc = 0;
        while (got < 10 && cyc < 60) begin
            Stall_D = cyc[0];
            Flush   = 1'b0;
            Fetch_Valid = (sent < 10) && !Stall_F;
            PC_F    = 32'h3000 + 32'(4*sent);
            Instr_F = PC_F ^ 32'hA5A5_0000;
            if (Valid_D && !Stall_D) begin
                if (PC_D !== 32'h3000 + 32'(4*got) || Instr_D !== ((32'h3000 + 32'(4*got)) ^ 32'hA5A5_0000)) begin
                    errs++;
                    $display("FAIL wrap_order idx=%0d got=%h exp=%h", got, PC_D, 32'h3000 + 32'(4*got));
                end
                got++;
            end
            if (Fetch_Valid) sent++;
            step();
            if (int'(Count) > maxc) maxc = int'(Count);
            cyc++;
        end
        checks++; if (errs != 0) failures++;
        checks++; if (got != 10) begin failures++; $display("FAIL wrap_count got=%0d exp=10", got); end
        checks++; if (maxc > 4) begin failures++; $display("FAIL wrap_max got=%0d exp<=4", maxc); end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        step();
        checks++; if (Count !== 3'd0) begin failures++; $display("FAIL wrap_empty got=%0d exp=0", Count); end
    endtask

    task automatic fill3();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h3000 + 32'(4*i), 1'b1, 1'b0);
            step();
        end
    endtask

    task automatic test_flush();
        fill3();
        checks++; if (Count !== 3'd3) begin failures++; $display("FAIL flush_pre got=%0d exp=3", Count); end
`ifdef DELAY_SLOT_EN
        drive(1'b1, 32'h300C, 1'b0, 1'b0);
        step();
        checks++; if (Count !== 3'd3 || PC_D !== 32'h3004) begin failures++; $display("FAIL ds_pre got=%0d/%h exp=3/00003004", Count, PC_D); end
        drive(1'b1, 32'h3010, 1'b0, 1'b1);
        step();
        checks++; if (Count !== 3'd1 || PC_D !== 32'h3004) begin failures++; $display("FAIL ds_keep got=%0d/%h exp=1/00003004", Count, PC_D); end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        step();
        checks++; if (Count !== 3'd0) begin failures++; $display("FAIL ds_drain got=%0d exp=0", Count); end
        drive(1'b1, 32'h3008, 1'b1, 1'b1);
        step();
        checks++; if (Count !== 3'd1 || PC_D !== 32'h3008) begin failures++; $display("FAIL ds_empty got=%0d/%h exp=1/00003008", Count, PC_D); end
`else
        drive(1'b1, 32'h300C, 1'b1, 1'b1);
        step();
        checks++; if (Count !== 3'd0 || Valid_D !== 1'b0 || PC_D !== 32'h0) begin failures++; $display("FAIL flush_clear got=%0d/%b/%h exp=0/0/0", Count, Valid_D, PC_D); end
        drive(1'b1, 32'h4000, 1'b1, 1'b0);
        step();
        checks++; if (Count !== 3'd1 || PC_D !== 32'h4000 || Instr_D !== (32'h4000 ^ 32'hA5A5_0000))
            begin failures++; $display("FAIL flush_restart got=%0d/%h exp=1/00004000", Count, PC_D); end
`endif
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        step();
        checks++; if (Count !== 3'd0) begin failures++; $display("FAIL flush_end got=%0d exp=0", Count); end
    endtask

    task automatic test_reset_mid();
        fill3();
        RESET = 1'b0;
        drive(1'b1, 32'h300C, 1'b0, 1'b1);
        step();
        RESET = 1'b1;
        checks++; if (Count !== 3'd0 || Valid_D !== 1'b0 || Stall_F !== 1'b0)
            begin failures++; $display("FAIL midreset_ctl got=%0d/%b/%b exp=0/0/0", Count, Valid_D, Stall_F); end
        checks++; if (PC_D !== 32'h0 || Instr_D !== 32'h0) begin failures++; $display("FAIL midreset_data got=%h/%h exp=0/0", PC_D, Instr_D); end
        drive(1'b1, 32'h5000, 1'b1, 1'b0);
        step();
        checks++; if (Count !== 3'd1 || PC_D !== 32'h5000) begin failures++; $display("FAIL midreset_push got=%0d/%h exp=1/00005000", Count, PC_D); end
    endtask

    initial begin
        test_reset();
        test_fill_full();
        test_wrap();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
